// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-requester Wishbone arbiter: FSM state encodings
// and the one-hot grant values.
package wb_arb_pkg;

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] GRANT_M0 = 2'b01;
  localparam logic [1:0] GRANT_M1 = 2'b10;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  function automatic logic [1:0] state_to_grant(input logic [1:0] st);
    case (st)
      GRANT_M0: state_to_grant = GNT_M0;
      GRANT_M1: state_to_grant = GNT_M1;
      default:  state_to_grant = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the external bus.
// master = arbiter view, slave = requester/bus environment view.
interface wb_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // Handshake: a requester holds start_read/start_write (level) until it sees
  // its done pulse; the bus signals one finished beat with i_wb_done for one
  // cycle. lock held at done keeps the grant for the next beat.
  logic                  i_m0_start_read;
  logic                  i_m0_start_write;
  logic                  i_m0_lock;
  logic [ADDR_WIDTH-1:0] i_m0_addr;
  logic [DATA_WIDTH-1:0] i_m0_wdata;
  logic [SEL_WIDTH-1:0]  i_m0_sel;
  logic                  o_m0_done;

  logic                  i_m1_start_read;
  logic                  i_m1_start_write;
  logic                  i_m1_lock;
  logic [ADDR_WIDTH-1:0] i_m1_addr;
  logic [DATA_WIDTH-1:0] i_m1_wdata;
  logic [SEL_WIDTH-1:0]  i_m1_sel;
  logic                  o_m1_done;

  logic [DATA_WIDTH-1:0] o_read_data;
  logic                  o_start_read_wb;
  logic                  o_start_write_wb;
  logic [SEL_WIDTH-1:0]  o_write_sel_wb;
  logic [DATA_WIDTH-1:0] o_write_data_wb;
  logic [ADDR_WIDTH-1:0] o_addr_wb;
  logic [DATA_WIDTH-1:0] i_read_data_wb;
  logic                  i_wb_done;
  logic [1:0]            o_grant;
  logic                  o_bus_err;

  modport master (
    input  i_m0_start_read, i_m0_start_write, i_m0_lock, i_m0_addr, i_m0_wdata, i_m0_sel,
    input  i_m1_start_read, i_m1_start_write, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_sel,
    input  i_read_data_wb, i_wb_done,
    output o_m0_done, o_m1_done, o_read_data,
    output o_start_read_wb, o_start_write_wb, o_write_sel_wb, o_write_data_wb, o_addr_wb,
    output o_grant, o_bus_err
  );

  modport slave (
    output i_m0_start_read, i_m0_start_write, i_m0_lock, i_m0_addr, i_m0_wdata, i_m0_sel,
    output i_m1_start_read, i_m1_start_write, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_sel,
    output i_read_data_wb, i_wb_done,
    input  o_m0_done, o_m1_done, o_read_data,
    input  o_start_read_wb, o_start_write_wb, o_write_sel_wb, o_write_data_wb, o_addr_wb,
    input  o_grant, o_bus_err
  );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter: counts granted cycles without a bus done and
// flags the terminal count. Only built when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic done,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  // A real done in the terminal cycle wins; no error is flagged then.
  assign expired = active && !done && (cnt == TC);

  // Idle cycles hold the count at zero, so every new grant starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !active || done || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter with burst lock sharing one Wishbone-style master port
// between m0 (cache block engine) and m1 (uncached path). Optional watchdog: WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                arst,
  wb_bus_arbiter_if.master    bus,
  output logic [1:0]          dbg_state
);

  if (DATA_WIDTH % 8 != 0 || ADDR_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_bus_arbiter: unsupported parameter values");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       rr_last;
  logic       rr_last_nxt;
  logic       req0;
  logic       req1;
  logic       tmo;

  assign req0 = bus.i_m0_start_read | bus.i_m0_start_write;
  assign req1 = bus.i_m1_start_read | bus.i_m1_start_write;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (arst),
    .active  (state != IDLE),
    .done    (bus.i_wb_done),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  assign bus.o_bus_err = tmo;

  // rr_last names the requester served last; the other one wins a tie.
  always_comb begin
    state_nxt   = state;
    rr_last_nxt = rr_last;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || rr_last)) begin
          state_nxt = GRANT_M0;
        end else if (req1) begin
          state_nxt = GRANT_M1;
        end
      end
      GRANT_M0: begin
        if (tmo) begin
          state_nxt   = IDLE;
          rr_last_nxt = 1'b0;
        end else if (bus.i_wb_done) begin
          rr_last_nxt = 1'b0;
          if (!bus.i_m0_lock) state_nxt = IDLE;
        end else if (!req0 && !bus.i_m0_lock) begin
          state_nxt = IDLE;
        end
      end
      GRANT_M1: begin
        if (tmo) begin
          state_nxt   = IDLE;
          rr_last_nxt = 1'b1;
        end else if (bus.i_wb_done) begin
          rr_last_nxt = 1'b1;
          if (!bus.i_m1_lock) state_nxt = IDLE;
        end else if (!req1 && !bus.i_m1_lock) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  // Bus mux: write beats a simultaneous read from the same requester.
  always_comb begin
    bus.o_start_read_wb  = 1'b0;
    bus.o_start_write_wb = 1'b0;
    bus.o_write_sel_wb   = '0;
    bus.o_write_data_wb  = '0;
    bus.o_addr_wb        = '0;
    case (state)
      GRANT_M0: begin
        bus.o_start_write_wb = bus.i_m0_start_write;
        bus.o_start_read_wb  = bus.i_m0_start_read & ~bus.i_m0_start_write;
        bus.o_write_sel_wb   = bus.i_m0_sel;
        bus.o_write_data_wb  = bus.i_m0_wdata;
        bus.o_addr_wb        = bus.i_m0_addr;
      end
      GRANT_M1: begin
        bus.o_start_write_wb = bus.i_m1_start_write;
        bus.o_start_read_wb  = bus.i_m1_start_read & ~bus.i_m1_start_write;
        bus.o_write_sel_wb   = bus.i_m1_sel;
        bus.o_write_data_wb  = bus.i_m1_wdata;
        bus.o_addr_wb        = bus.i_m1_addr;
      end
      default: ;
    endcase
  end

  assign bus.o_m0_done   = (state == GRANT_M0) && (bus.i_wb_done || tmo);
  assign bus.o_m1_done   = (state == GRANT_M1) && (bus.i_wb_done || tmo);
  assign bus.o_read_data = bus.i_read_data_wb;
  assign bus.o_grant     = state_to_grant(state);
  assign dbg_state       = state;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising (active) edge.
module tb_wb_bus_arbiter;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [1:0] dbg_state;
  int         n_assert = 0;
  int         n_fail = 0;
  int         err_early;
  logic       seen_err = 1'b0;

  wb_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  wb_bus_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .bus       (bus_if.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit: got still running expected finished");
    $fatal(1, "time limit");
  end

  always @(negedge clk) if (bus_if.o_bus_err) seen_err = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus_if.i_m0_start_read = 0; bus_if.i_m0_start_write = 0; bus_if.i_m0_lock = 0;
    bus_if.i_m0_addr = 0; bus_if.i_m0_wdata = 0; bus_if.i_m0_sel = 0;
    bus_if.i_m1_start_read = 0; bus_if.i_m1_start_write = 0; bus_if.i_m1_lock = 0;
    bus_if.i_m1_addr = 0; bus_if.i_m1_wdata = 0; bus_if.i_m1_sel = 0;
    bus_if.i_read_data_wb = 0; bus_if.i_wb_done = 0;
  endtask

  task automatic do_reset(input bit with_checks);
    arst = 1'b1;
    clear_inputs();
    step(); step(); step();
    #1;
    if (with_checks) begin
      check_eq("rst_grant", bus_if.o_grant, 2'b00);
      check_eq("rst_state", dbg_state, 2'b00);
      check_eq("rst_bus", {bus_if.o_start_read_wb, bus_if.o_start_write_wb, bus_if.o_write_sel_wb,
                           bus_if.o_addr_wb, bus_if.o_write_data_wb[15:0]}, 0);
      check_eq("rst_done", {bus_if.o_m0_done, bus_if.o_m1_done, bus_if.o_bus_err}, 3'b000);
    end
    arst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    do_reset(1'b1);

    // single m1 read, one cycle arbitration latency
    step();
    bus_if.i_m1_start_read = 1; bus_if.i_m1_addr = 32'h0000_1004; bus_if.i_m1_sel = 4'hF;
    #1 check_eq("t1_latency", bus_if.o_grant, 2'b00);
    step(); #1;
    check_eq("t1_grant", bus_if.o_grant, 2'b10);
    check_eq("t1_addr", bus_if.o_addr_wb, 32'h0000_1004);
    check_eq("t1_rd_wr", {bus_if.o_start_read_wb, bus_if.o_start_write_wb}, 2'b10);
    bus_if.i_wb_done = 1; bus_if.i_read_data_wb = 32'hDEAD_BEEF;
    #1;
    check_eq("t1_dones", {bus_if.o_m1_done, bus_if.o_m0_done}, 2'b10);
    check_eq("t1_rdata", bus_if.o_read_data, 32'hDEAD_BEEF);
    step(); bus_if.i_wb_done = 0;
    #1 check_eq("t1_idle_after_done", bus_if.o_grant, 2'b00);
    step(); #1 check_eq("t1_regrant", bus_if.o_grant, 2'b10);
    bus_if.i_m1_start_read = 0;
    step(); #1 check_eq("t1_abandon", bus_if.o_grant, 2'b00);

    // simultaneous requests after reset, then fairness
    do_reset(1'b0);
    bus_if.i_m0_start_read = 1; bus_if.i_m0_addr = 32'h100;
    bus_if.i_m1_start_write = 1; bus_if.i_m1_addr = 32'h200; bus_if.i_m1_wdata = 32'hA5A5;
    step(); #1;
    check_eq("t2_first_m0", bus_if.o_grant, 2'b01);
    check_eq("t2_addr_m0", bus_if.o_addr_wb, 32'h100);
    bus_if.i_wb_done = 1;
    #1 check_eq("t2_m0_done", {bus_if.o_m1_done, bus_if.o_m0_done}, 2'b01);
    step(); bus_if.i_m0_start_read = 0; bus_if.i_wb_done = 0;
    #1 check_eq("t2_idle", bus_if.o_grant, 2'b00);
    step(); #1;
    check_eq("t2_then_m1", bus_if.o_grant, 2'b10);
    check_eq("t2_m1_write", {bus_if.o_start_write_wb, bus_if.o_addr_wb, bus_if.o_write_data_wb},
             {1'b1, 32'h200, 32'hA5A5});
    bus_if.i_wb_done = 1; bus_if.i_m0_start_read = 1;
    #1 check_eq("t2_m1_done", {bus_if.o_m1_done, bus_if.o_m0_done}, 2'b10);
    step(); bus_if.i_wb_done = 0;
    #1 check_eq("t2_idle2", bus_if.o_grant, 2'b00);
    step(); #1 check_eq("t2_fair_m0", bus_if.o_grant, 2'b01);
    bus_if.i_wb_done = 1;
    step(); clear_inputs();
    bus_if.i_wb_done = 1;
    #1 check_eq("t2_idle_done_ignored", {bus_if.o_m1_done, bus_if.o_m0_done, bus_if.o_grant}, 4'b0000);
    step(); bus_if.i_wb_done = 0;

    // locked 8-beat m0 burst, m1 arrives at beat 2
    bus_if.i_m0_start_read = 1; bus_if.i_m0_lock = 1; bus_if.i_m0_addr = 32'h2000;
    step(); #1 check_eq("t3_grant", bus_if.o_grant, 2'b01);
    for (int b = 0; b < 8; b++) begin
      bus_if.i_m0_lock = (b < 7);
      bus_if.i_m0_addr = 32'h2000 + 32'(b * 4);
      bus_if.i_wb_done = 1;
      if (b == 2) begin bus_if.i_m1_start_read = 1; bus_if.i_m1_addr = 32'h3000; end
      if (b == 7) bus_if.i_m1_lock = 1;
      #1;
      check_eq($sformatf("t3_beat%0d", b), {bus_if.o_grant, bus_if.o_m0_done, bus_if.o_m1_done}, 4'b0110);
      step(); bus_if.i_wb_done = 0;
      if (b < 7) begin
        #1 check_eq($sformatf("t3_hold%0d", b), bus_if.o_grant, 2'b01);
        step();
      end
    end
    bus_if.i_m0_start_read = 0; bus_if.i_m0_lock = 0; bus_if.i_m1_lock = 0;
    #1 check_eq("t3_idle_after_burst", bus_if.o_grant, 2'b00);
    step(); #1;
    check_eq("t3_m1_after", bus_if.o_grant, 2'b10);
    check_eq("t3_m1_addr", bus_if.o_addr_wb, 32'h3000);
    bus_if.i_wb_done = 1;
    step(); clear_inputs();
    #1 check_eq("t3_done_idle", bus_if.o_grant, 2'b00);

    // read+write together from m0: write wins
    bus_if.i_m0_start_read = 1; bus_if.i_m0_start_write = 1; bus_if.i_m0_sel = 4'hF;
    bus_if.i_m0_wdata = 32'h1234_5678; bus_if.i_m0_addr = 32'h4000;
    step(); #1;
    check_eq("t4_grant", bus_if.o_grant, 2'b01);
    check_eq("t4_wr_rd", {bus_if.o_start_write_wb, bus_if.o_start_read_wb}, 2'b10);
    check_eq("t4_wdata", bus_if.o_write_data_wb, 32'h1234_5678);
    check_eq("t4_sel", bus_if.o_write_sel_wb, 4'hF);
    bus_if.i_wb_done = 1;
    step(); clear_inputs();
    #1 check_eq("t4_idle", bus_if.o_grant, 2'b00);

    // reset during beat 3 of a locked burst
    bus_if.i_m0_start_read = 1; bus_if.i_m0_lock = 1; bus_if.i_m0_addr = 32'h5000;
    step(); #1 check_eq("t5_grant", bus_if.o_grant, 2'b01);
    for (int b = 0; b < 3; b++) begin
      bus_if.i_wb_done = 1;
      step(); bus_if.i_wb_done = 0;
      step();
    end
    arst = 1'b1;
    step(); #1;
    check_eq("t5_rst_state", dbg_state, 2'b00);
    check_eq("t5_rst_bus", {bus_if.o_grant, bus_if.o_start_read_wb, bus_if.o_addr_wb}, 0);
    arst = 1'b0;
    bus_if.i_m1_start_read = 1; bus_if.i_m1_addr = 32'h6000;
    step(); #1 check_eq("t5_tie_m0", bus_if.o_grant, 2'b01);
    bus_if.i_m0_lock = 0; bus_if.i_wb_done = 1;
    step(); bus_if.i_m0_start_read = 0; bus_if.i_wb_done = 0;
    step(); #1 check_eq("t5_m1_next", bus_if.o_grant, 2'b10);
    bus_if.i_m1_start_read = 0;
    step(); #1 check_eq("t5_idle", bus_if.o_grant, 2'b00);
    clear_inputs();

`ifdef WB_ARB_TIMEOUT_EN
    // stalled bus: watchdog ends the beat
    bus_if.i_m1_start_read = 1; bus_if.i_m1_lock = 1; bus_if.i_m1_addr = 32'h7000;
    step(); #1 check_eq("t6_grant", bus_if.o_grant, 2'b10);
    err_early = 0;
    for (int i = 1; i < 16; i++) begin
      step(); #1;
      if (bus_if.o_bus_err || bus_if.o_m1_done) err_early++;
    end
    check_eq("t6_no_early_err", err_early, 0);
    step(); #1 check_eq("t6_timeout", {bus_if.o_m1_done, bus_if.o_bus_err}, 2'b11);
    step(); #1 check_eq("t6_idle", {bus_if.o_grant, bus_if.o_bus_err}, 3'b000);
    clear_inputs();
`else
    err_early = 0;
    check_eq("no_bus_err", seen_err, 1'b0);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the single Wishbone-style master port (start_read/start_write/sel/wdata/addr, done/rdata) between two requesters.
- m0 is the cache block-transfer engine and issues 8-beat bursts. m1 is the non-cacheable single-access path.
- Round-robin arbitration with a burst lock, so an m0 block transfer is never interleaved.
- Sits between the datapath/transfer units and the external bus pins.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; sel width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- arst  in  1  reset, synchronous, active-high.
- i_m0_start_read  in  1  m0 read request, level, held until m0 done.
- i_m0_start_write  in  1  m0 write request, level.
- i_m0_lock  in  1  m0 keeps the grant after the current beat completes.
- i_m0_addr  in  ADDR_WIDTH  m0 address.
- i_m0_wdata  in  DATA_WIDTH  m0 write data.
- i_m0_sel  in  DATA_WIDTH/8  m0 byte select.
- o_m0_done  out  1  m0 beat complete.
- i_m1_start_read, i_m1_start_write, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_sel  in  as m0  m1 request set.
- o_m1_done  out  1  m1 beat complete.
- o_read_data  out  DATA_WIDTH  i_read_data_wb broadcast to both requesters.
- o_start_read_wb, o_start_write_wb  out  1  bus request.
- o_write_sel_wb  out  DATA_WIDTH/8  bus byte select.
- o_write_data_wb  out  DATA_WIDTH  bus write data.
- o_addr_wb  out  ADDR_WIDTH  bus address.
- i_read_data_wb  in  DATA_WIDTH  bus read data.
- i_wb_done  in  1  bus beat complete.
- o_grant  out  2  one-hot current owner; 00 when idle.
- o_bus_err  out  1  watchdog timeout pulse; tied 0 without the macro.

Behaviour:
- Clock and reset: one clock, clk. Reset port arst is synchronous and active-high.
- States: IDLE, GRANT_M0, GRANT_M1. Registered state and a 1-bit priority pointer rr_last (last served).
- Reset:
  - state=IDLE, rr_last=1, so m0 wins the first tie.
  - All bus outputs, o_grant, done signals and o_bus_err are 0.
  - Reset mid-transfer abandons the beat; the bus sees start drop in the next cycle.
- Request definition: req_x = start_read_x | start_write_x.
- IDLE arbitration:
  - If only one req_x is high, go to GRANT_x.
  - If both are high, grant the requester that is not rr_last.
  - Arbitration latency is 1 cycle: bus start is first asserted in the cycle after the request is seen.
- GRANT_x, bus drive:
  - Bus outputs are driven combinationally from requester x.
  - When not granted, all bus outputs are 0.
- GRANT_x, done routing:
  - o_mx_done = i_wb_done in GRANT_x.
  - The other requester's done is always 0.
- GRANT_x, end of beat (i_wb_done=1):
  - Set rr_last=x.
  - If lock_x=1, stay in GRANT_x.
  - Otherwise go to IDLE; there is no back-to-back regrant without passing through IDLE.
- GRANT_x, abandoned request: if req_x=0 and lock_x=0 without done, go to IDLE with no pointer update.
- Same requester raises read and write together: write wins; o_start_read_wb is forced 0.
- i_wb_done in IDLE: ignored; neither done is asserted.
- Lock from a non-owner has no effect.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on each grant and on each i_wb_done.
  - It increments every GRANT_x cycle without done.
  - When it reaches TIMEOUT_CYCLES, that cycle asserts o_mx_done=1 and o_bus_err=1 for one cycle.
  - State is forced to IDLE regardless of lock, and rr_last=x.
- Without the macro: no counter is built; o_bus_err=0 constant; a stalled bus hangs the owner indefinitely.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum (IDLE, GRANT_M0, GRANT_M1);
  - grant one-hot constants GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10.
- One natural sub-module, wb_arb_watchdog: counter, clear and terminal-count flag. It is instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- Reset, then m1 read of addr 0x0000_1004 at cycle 2. Required: o_grant=10 at cycle 3 with o_addr_wb=0x1004. Bus returns done with data 0xDEADBEEF. Required: o_m1_done=1, o_read_data=0xDEADBEEF, o_grant=00 next cycle.
- m0 and m1 request in the same cycle straight after reset. Required: m0 granted first. After m0's unlocked beat, m1 is granted; if both then request again, m0 is granted (fairness).
- m0 8-beat burst with lock=1 on beats 0-6 and lock=0 on beat 7; m1 requests during beat 2. Required: m1 sees no grant until after beat 7's done, and o_grant=01 throughout the burst.
- m0 raises write and read together, sel=4'hF, wdata=0x12345678. Required: o_start_write_wb=1, o_start_read_wb=0, o_write_data_wb=0x12345678.
- arst asserted mid-burst at beat 3. Required: the following cycle state=IDLE, all bus outputs 0, and m0 wins the next tie.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, m1 requests and the bus never returns done. Required: o_m1_done=1 and o_bus_err=1 together after 16 granted cycles, then IDLE.
